// File: rtl/cpu_pkg.sv
// cpu_pkg: write-back source and destination-select encodings plus default datapath widths
package cpu_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_LINK, WB_RSVD} wb_src_e;
  typedef enum logic [1:0] {DST_RT, DST_RD, DST_LINK, DST_NONE} dst_sel_e;
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: busy-bit vector (set beats clear) and RAW stall; ports clk, rst_n, setEn/setIdx, clrEn/clrIdx, qEn/qIdx1/qIdx2/use2 query, stall
module reg_scoreboard
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              setEn,
  input  logic [ADDR_W-1:0] setIdx,
  input  logic              clrEn,
  input  logic [ADDR_W-1:0] clrIdx,
  input  logic              qEn,
  input  logic [ADDR_W-1:0] qIdx1,
  input  logic [ADDR_W-1:0] qIdx2,
  input  logic              use2,
  output logic              stall
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DEPTH-1:0] busy;
  logic hz1, hz2;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) busy <= '0;
    else begin
      if (clrEn) busy[clrIdx] <= 1'b0;
      if (setEn) busy[setIdx] <= 1'b1;
    end
  assign hz1   = busy[qIdx1] & ~(clrEn && clrIdx == qIdx1);
  assign hz2   = busy[qIdx2] & ~(clrEn && clrIdx == qIdx2);
  assign stall = qEn & (hz1 | (use2 & hz2));
endmodule

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: register file with forwarded registered reads, wb mux, dest resolve, busy scoreboard; ports: read (readEn/readReg1/2/use2 -> readData1/2, stall), issue (issueEn/Rt/Rd/regDst -> issueDest), write-back (wbEn/wbReg/wbSrc/wbData*), zeroWrErr
module reg_file_scoreboard
  import cpu_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int ZERO_REG_EN = 1,
  parameter int LINK_REG    = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              readEn,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  input  logic              use2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  output logic              stall,
  input  logic              issueEn,
  input  logic [ADDR_W-1:0] issueRt,
  input  logic [ADDR_W-1:0] issueRd,
  input  logic [1:0]        regDst,
  output logic [ADDR_W-1:0] issueDest,
  input  logic              wbEn,
  input  logic [ADDR_W-1:0] wbReg,
  input  logic [1:0]        wbSrc,
  input  logic [DATA_W-1:0] wbDataALU,
  input  logic [DATA_W-1:0] wbDataMem,
  input  logic [DATA_W-1:0] wbDataLink,
  output logic              zeroWrErr
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DATA_W-1:0] wr_data, fwd1, fwd2;
  logic [ADDR_W-1:0] dest;
  logic wb_ok, wr_en, set_en;
  assign wb_ok   = wbEn & (wbSrc != WB_RSVD);
  assign wr_en   = wb_ok & ~(ZERO_REG_EN != 0 && wbReg == '0);
  assign wr_data = wbSrc == WB_ALU ? wbDataALU : wbSrc == WB_MEM ? wbDataMem : wbDataLink;
  assign fwd1    = (wr_en && wbReg == readReg1) ? wr_data
                 : (ZERO_REG_EN != 0 && readReg1 == '0) ? '0 : regs[readReg1];
  assign fwd2    = (wr_en && wbReg == readReg2) ? wr_data
                 : (ZERO_REG_EN != 0 && readReg2 == '0) ? '0 : regs[readReg2];
  assign dest    = regDst == DST_RT ? issueRt : regDst == DST_RD ? issueRd
                 : regDst == DST_LINK ? ADDR_W'(LINK_REG) : '0;
  assign set_en  = issueEn & (regDst != DST_NONE) & ~(ZERO_REG_EN != 0 && dest == '0);
  reg_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk(clk), .rst_n(rst_n),
    .setEn(set_en), .setIdx(dest),
    .clrEn(wb_ok), .clrIdx(wbReg),
    .qEn(readEn), .qIdx1(readReg1), .qIdx2(readReg2), .use2(use2),
    .stall(stall)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      readData1 <= '0;
      readData2 <= '0;
      issueDest <= '0;
      zeroWrErr <= 1'b0;
    end else begin
      if (wr_en) regs[wbReg] <= wr_data;
      if (readEn && !stall) begin
        readData1 <= fwd1;
        readData2 <= fwd2;
      end
      if (issueEn) issueDest <= dest;
      zeroWrErr <= wbEn && ZERO_REG_EN != 0 && wbReg == '0;
    end
  a_wb_src: assert property (@(posedge clk) disable iff (!rst_n) wbEn |-> wbSrc != WB_RSVD);
  a_issue_stall: assert property (@(posedge clk) disable iff (!rst_n) issueEn |-> !stall);
endmodule

// File: doc/reg_file_scoreboard.md
Name: reg_file_scoreboard

Overview:
Parametrised next-generation register file for the CPU datapath.
- Registered reads with write-to-read forwarding.
- Write-back source select: ALU, memory, or link/PC.
- Destination select: rt, rd, or the link register.
- A busy-bit scoreboard. It tracks registers that have an in-flight producer and raises a stall to the decode stage on a read-after-write hazard.
- Sits between decode (read and issue ports) and write-back (write port).

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 5, register address width; depth is 2**ADDR_W.
- ZERO_REG_EN, 1, when 1, register 0 is hardwired to zero.
- LINK_REG, 31, destination index used when regDst selects link.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- readEn  in  1  decode requests operand read this cycle.
- readReg1  in  ADDR_W  source register 1 (rs).
- readReg2  in  ADDR_W  source register 2 (rt).
- use2  in  1  readReg2 is a true source; when 0, rt is excluded from the hazard check.
- readData1  out  DATA_W  registered operand 1.
- readData2  out  DATA_W  registered operand 2.
- stall  out  1  combinational RAW hazard; decode must hold.
- issueEn  in  1  instruction with a destination issues this cycle.
- issueRt  in  ADDR_W  rt field of the issuing instruction.
- issueRd  in  ADDR_W  rd field of the issuing instruction.
- regDst  in  2  destination select: 0 = rt, 1 = rd, 2 = LINK_REG, 3 = none.
- issueDest  out  ADDR_W  registered resolved destination; write-back carries it back.
- wbEn  in  1  write-back valid.
- wbReg  in  ADDR_W  write-back destination.
- wbSrc  in  2  write-back data select: 0 = ALU, 1 = Mem, 2 = Link, 3 = reserved.
- wbDataALU  in  DATA_W  ALU result.
- wbDataMem  in  DATA_W  memory load data.
- wbDataLink  in  DATA_W  return address (PC+8).
- zeroWrErr  out  1  one-cycle pulse: write-back targeted register 0 while ZERO_REG_EN is 1.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registers, readData1/2, issueDest, zeroWrErr and every busy bit go to 0.
  - Deassertion takes effect at the next rising edge.
- Write data select:
  - wbSrc 0 selects ALU, 1 selects Mem, 2 selects Link.
  - wbSrc 3 suppresses the write, leaves busy unchanged, and is flagged by an assertion in simulation.
- Write: at a rising edge with wbEn=1, reg[wbReg] <= selected data.
- Register 0 (ZERO_REG_EN=1):
  - Writes to register 0 are dropped, and zeroWrErr pulses on the next cycle.
  - Reads of register 0 return 0.
  - Register 0 is never busy.
- Read:
  - At a rising edge with readEn=1 and stall=0, readData1/2 <= reg[readReg1/2]. Latency is 1 cycle.
  - Otherwise readData1/2 hold their value.
- Forwarding: if wbEn=1 and wbReg equals a read address (and is nonzero or zero-reg is disabled) in the same cycle, the read captures the write data, not the old contents.
- Destination resolution:
  - dest = issueRt, issueRd, LINK_REG or none, per regDst.
  - issueDest <= dest on issueEn; issueDest is 0 for "none".
- Scoreboard set: on issueEn with dest not none and not register 0, busy[dest] <= 1.
- Scoreboard clear: on wbEn (with wbSrc not 3), busy[wbReg] <= 0.
- Simultaneous set and clear of the same index: set wins, because a new producer has been issued.
- Stall equation: stall = readEn & (hz1 | (use2 & hz2)).
  - hzN = busy[readRegN] & ~(wbEn & wbReg == readRegN). A same-cycle write-back resolves the hazard through forwarding.
- Issue during a stall: issueEn asserted while stall=1 is a protocol error; decode must gate it. Verification checks this with an assertion.
- Write-back to a non-busy register is legal: data is written and busy stays 0.
- Reset mid-operation: all busy bits clear; in-flight write-backs after reset are written normally.

Decomposition:
- Shared package cpu_pkg holds:
  - WB_ALU / WB_MEM / WB_LINK / WB_RSVD encodings.
  - DST_RT / DST_RD / DST_LINK / DST_NONE encodings.
  - Default DATA_W / ADDR_W constants.
- Sub-module reg_scoreboard (parameter ADDR_W):
  - Holds the busy vector with set/clear priority.
  - Contains the stall combinational logic.
  - Ports: clk, rst_n, setEn, setIdx, clrEn, clrIdx, the two query indices with use2, and stall.
- The storage array, write mux, forwarding and destination resolution stay in the top module.

Test Plan:
- Reset, then write 0xDEADBEEF from ALU to r5, then read r5/r0 on the next cycle -> readData1=0xDEADBEEF, readData2=0, stall=0.
- wbEn to r7 with Mem data 0x1234 in the same cycle as readEn with readReg1=7 -> readData1=0x1234 after 1 cycle (forwarded).
- Issue with regDst=1, issueRd=9, then readEn with readReg1=9 on the next cycle -> stall=1 and readData unchanged; write-back to r9 of 0x55 -> stall drops that cycle and readData1=0x55.
- regDst=2 issue, then Link write-back 0x00400008 -> issueDest=31, busy[31] set then cleared, reg31=0x00400008.
- wbEn to r0 with 0xFFFF -> r0 still reads 0 and zeroWrErr pulses for exactly 1 cycle; issue with dest r0 -> no stall on a later read of r0.
- busy[4] set, then rst_n low for 1 cycle -> readData1/2=0, busy clear, a read of r4 with use2=0 and readReg2=4 gives stall=0.
